// File: rtl/i2c_reg_target_if.sv
// Bus bundle between the I2C target and its surroundings: I2C pads
// (scl_in, sda_in, sda_oe), register-map bus (reg_*) and busy flag.
interface i2c_reg_target_if;
    logic       scl_in;
    logic       sda_in;
    logic       sda_oe;
    logic [3:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_we;
    logic [7:0] reg_rdata;
    logic       busy;

    modport slave (
        input  scl_in, sda_in, reg_rdata,
        output sda_oe, reg_addr, reg_wdata, reg_we, busy
    );

    modport master (
        output scl_in, sda_in, reg_rdata,
        input  sda_oe, reg_addr, reg_wdata, reg_we, busy
    );
endinterface

// File: rtl/i2c_reg_target.sv
// I2C target front end for a 16-entry register map (oversampled SCL/SDA).
// Ports: clk, rstn (async low), bus (slave: pads, reg_* map bus, busy).
module i2c_reg_target #(
    parameter logic [6:0] I2C_ADDR    = 7'h2A,
    parameter int         SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rstn,
    i2c_reg_target_if.slave  bus
);

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK,
        WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT_STOP
    } state_t;

    state_t state, state_n;

    logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
    logic scl_s, sda_s, scl_d, sda_d;
    logic scl_rise, scl_fall, start, stop;

    logic [3:0] bit_cnt, bit_cnt_n;
    logic [7:0] shift, shift_n;
    logic       rw, rw_n;
    logic       oe, oe_n;
    logic [3:0] addr, addr_n;
    logic [7:0] wdata, wdata_n;
    logic       we, we_n;

    // Sync chains reset to 1 so an idle bus gives no edge after reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], bus.scl_in};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], bus.sda_in};
            scl_d    <= scl_s;
            sda_d    <= sda_s;
        end
    end

    assign scl_s    = scl_sync[SYNC_STAGES-1];
    assign sda_s    = sda_sync[SYNC_STAGES-1];
    assign scl_rise = scl_s & ~scl_d;
    assign scl_fall = ~scl_s & scl_d;
    assign start    = scl_s & scl_d & sda_d & ~sda_s;
    assign stop     = scl_s & scl_d & ~sda_d & sda_s;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= IDLE;
            bit_cnt <= 4'd0;
            shift   <= 8'd0;
            rw      <= 1'b0;
            oe      <= 1'b0;
            addr    <= 4'd0;
            wdata   <= 8'd0;
            we      <= 1'b0;
        end else begin
            state   <= state_n;
            bit_cnt <= bit_cnt_n;
            shift   <= shift_n;
            rw      <= rw_n;
            oe      <= oe_n;
            addr    <= addr_n;
            wdata   <= wdata_n;
            we      <= we_n;
        end
    end

    always_comb begin
        state_n   = state;
        bit_cnt_n = bit_cnt;
        shift_n   = shift;
        rw_n      = rw;
        oe_n      = oe;
        addr_n    = addr;
        wdata_n   = wdata;
        we_n      = 1'b0;

        // Pointer advances on the clk after each write strobe.
        if (we) addr_n = addr + 4'd1;

        if (start) begin
            state_n   = ADDR;
            bit_cnt_n = 4'd0;
            oe_n      = 1'b0;
        end else if (stop) begin
            state_n   = IDLE;
            bit_cnt_n = 4'd0;
            oe_n      = 1'b0;
        end else if (scl_rise) begin
            case (state)
                ADDR, PTR, WDATA: begin
                    shift_n   = {shift[6:0], sda_s};
                    bit_cnt_n = bit_cnt + 4'd1;
                end
                RDATA_ACK: begin
                    if (sda_s) state_n = WAIT_STOP;
                end
                default: ;
            endcase
        end else if (scl_fall) begin
            case (state)
                ADDR: begin
                    if (bit_cnt == 4'd8) begin
                        bit_cnt_n = 4'd0;
                        if (shift[7:1] == I2C_ADDR) begin
                            state_n = ADDR_ACK;
                            oe_n    = 1'b1;
                            rw_n    = shift[0];
                        end else begin
                            state_n = WAIT_STOP;
                        end
                    end
                end
                ADDR_ACK: begin
                    if (rw) begin
                        state_n   = RDATA;
                        shift_n   = bus.reg_rdata;
                        oe_n      = ~bus.reg_rdata[7];
                        bit_cnt_n = 4'd0;
                    end else begin
                        state_n = PTR;
                        oe_n    = 1'b0;
                    end
                end
                PTR: begin
                    if (bit_cnt == 4'd8) begin
                        addr_n    = shift[3:0];
                        oe_n      = 1'b1;
                        state_n   = PTR_ACK;
                        bit_cnt_n = 4'd0;
                    end
                end
                PTR_ACK, WDATA_ACK: begin
                    oe_n    = 1'b0;
                    state_n = WDATA;
                end
                WDATA: begin
                    if (bit_cnt == 4'd8) begin
                        wdata_n   = shift;
                        we_n      = 1'b1;
                        oe_n      = 1'b1;
                        state_n   = WDATA_ACK;
                        bit_cnt_n = 4'd0;
                    end
                end
                RDATA: begin
                    // bit_cnt counts bits already put on the bus.
                    if (bit_cnt == 4'd7) begin
                        oe_n      = 1'b0;
                        addr_n    = addr + 4'd1;
                        state_n   = RDATA_ACK;
                        bit_cnt_n = 4'd0;
                    end else begin
                        bit_cnt_n = bit_cnt + 4'd1;
                        shift_n   = {shift[6:0], 1'b0};
                        oe_n      = ~shift[6];
                    end
                end
                RDATA_ACK: begin
                    // Reaching this fall means the controller ACKed.
                    state_n   = RDATA;
                    shift_n   = bus.reg_rdata;
                    oe_n      = ~bus.reg_rdata[7];
                    bit_cnt_n = 4'd0;
                end
                default: ;
            endcase
        end
    end

    assign bus.sda_oe    = oe;
    assign bus.reg_addr  = addr;
    assign bus.reg_wdata = wdata;
    assign bus.reg_we    = we;
    assign bus.busy      = state inside {ADDR_ACK, PTR, PTR_ACK, WDATA,
                                         WDATA_ACK, RDATA, RDATA_ACK};

endmodule

// File: tb/tb_i2c_reg_target.sv
// Directed bench for i2c_reg_target: bit-banged I2C controller model,
// combinational register map, write log and SDA/strobe timing monitor.
module tb_i2c_reg_target;

    localparam int CP = 10;
    localparam int Q  = 8;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       scl = 1'b1;
    logic       sda_ctrl = 1'b1;
    logic       sda_bus;
    logic [7:0] rmap [16];

    int checks = 0;
    int failures = 0;

    logic [11:0] wlog [$];
    logic        oe_seen, busy_seen;
    logic        we_q = 1'b0, oe_q = 1'b0, rst_q = 1'b0;

    i2c_reg_target_if bus ();

    assign sda_bus       = sda_ctrl & ~bus.sda_oe;
    assign bus.scl_in    = scl;
    assign bus.sda_in    = sda_bus;
    assign bus.reg_rdata = rmap[bus.reg_addr];

    i2c_reg_target #(
        .I2C_ADDR    (7'h2A),
        .SYNC_STAGES (2)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #(CP/2) clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic hq();
        #(Q*CP);
    endtask

    task automatic i2c_start();
        sda_ctrl = 1'b1; hq();
        scl = 1'b1;      hq();
        sda_ctrl = 1'b0; hq();
        scl = 1'b0;      hq();
    endtask

    task automatic i2c_stop();
        sda_ctrl = 1'b0; hq();
        scl = 1'b1;      hq();
        sda_ctrl = 1'b1; hq();
    endtask

    task automatic clk_bit(input logic b, output logic s);
        sda_ctrl = b; hq();
        scl = 1'b1;   hq();
        s = sda_bus;  hq();
        scl = 1'b0;   hq();
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) clk_bit(b[i], s);
        clk_bit(1'b1, s);
        ack = ~s;
    endtask

    task automatic recv_byte(input logic nack, output logic [7:0] d);
        logic s;
        d = 8'h00;
        for (int i = 0; i < 8; i++) begin
            clk_bit(1'b1, s);
            d = {d[6:0], s};
        end
        clk_bit(nack, s);
    endtask

    task automatic clear_log();
        wlog.delete();
        oe_seen   = 1'b0;
        busy_seen = 1'b0;
    endtask

    initial begin
        logic       a;
        logic       s;
        logic [7:0] d0, d1;

        for (int i = 0; i < 16; i++) rmap[i] = 8'h00;
        rmap[7] = 8'h01;
        rmap[8] = 8'h3C;
        clear_log();

        fork
            forever begin
                @(negedge clk);
                if (rstn && rst_q) begin
                    if (bus.reg_we) begin
                        wlog.push_back({bus.reg_addr, bus.reg_wdata});
                        chk("we_one_clk", {31'd0, we_q}, 32'd0);
                    end
                    if (bus.sda_oe !== oe_q)
                        chk("oe_toggle_scl_low", {31'd0, scl}, 32'd0);
                    if (bus.sda_oe) oe_seen = 1'b1;
                    if (bus.busy) busy_seen = 1'b1;
                end
                we_q  = bus.reg_we;
                oe_q  = bus.sda_oe;
                rst_q = rstn;
            end
        join_none

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_oe", {31'd0, bus.sda_oe}, 32'd0);
        chk("rst_we", {31'd0, bus.reg_we}, 32'd0);
        chk("rst_addr", {28'd0, bus.reg_addr}, 32'd0);
        chk("rst_wdata", {24'd0, bus.reg_wdata}, 32'd0);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        rstn = 1'b1;
        hq();

        // Write burst
        clear_log();
        i2c_start();
        send_byte(8'h54, a); chk("t1_addr_ack", {31'd0, a}, 32'd1);
        chk("t1_busy", {31'd0, bus.busy}, 32'd1);
        send_byte(8'h01, a); chk("t1_ptr_ack", {31'd0, a}, 32'd1);
        send_byte(8'hA5, a); chk("t1_d0_ack", {31'd0, a}, 32'd1);
        send_byte(8'h00, a); chk("t1_d1_ack", {31'd0, a}, 32'd1);
        send_byte(8'h02, a); chk("t1_d2_ack", {31'd0, a}, 32'd1);
        i2c_stop();
        chk("t1_nwr", wlog.size(), 32'd3);
        chk("t1_wr0", {20'd0, wlog[0]}, 32'h1A5);
        chk("t1_wr1", {20'd0, wlog[1]}, 32'h200);
        chk("t1_wr2", {20'd0, wlog[2]}, 32'h302);
        chk("t1_addr", {28'd0, bus.reg_addr}, 32'd4);
        chk("t1_busy_end", {31'd0, bus.busy}, 32'd0);

        // Read with repeated START
        clear_log();
        i2c_start();
        send_byte(8'h54, a); chk("t2_addr_ack", {31'd0, a}, 32'd1);
        send_byte(8'h07, a); chk("t2_ptr_ack", {31'd0, a}, 32'd1);
        i2c_start();
        send_byte(8'h55, a); chk("t2_raddr_ack", {31'd0, a}, 32'd1);
        recv_byte(1'b0, d0);
        recv_byte(1'b1, d1);
        i2c_stop();
        chk("t2_byte0", {24'd0, d0}, 32'h01);
        chk("t2_byte1", {24'd0, d1}, 32'h3C);
        chk("t2_addr", {28'd0, bus.reg_addr}, 32'd9);
        chk("t2_nwr", wlog.size(), 32'd0);

        // Address mismatch
        clear_log();
        i2c_start();
        send_byte(8'h60, a); chk("t3_addr_nack", {31'd0, a}, 32'd0);
        send_byte(8'h05, a); chk("t3_b1_nack", {31'd0, a}, 32'd0);
        send_byte(8'hFF, a); chk("t3_b2_nack", {31'd0, a}, 32'd0);
        i2c_stop();
        chk("t3_oe_seen", {31'd0, oe_seen}, 32'd0);
        chk("t3_busy_seen", {31'd0, busy_seen}, 32'd0);
        chk("t3_nwr", wlog.size(), 32'd0);
        chk("t3_addr", {28'd0, bus.reg_addr}, 32'd9);

        // Pointer wrap and upper-nibble masking
        clear_log();
        i2c_start();
        send_byte(8'h54, a);
        send_byte(8'h0F, a);
        send_byte(8'h11, a);
        send_byte(8'h22, a); chk("t4_d1_ack", {31'd0, a}, 32'd1);
        i2c_stop();
        chk("t4_nwr", wlog.size(), 32'd2);
        chk("t4_wr0", {20'd0, wlog[0]}, 32'hF11);
        chk("t4_wr1", {20'd0, wlog[1]}, 32'h022);
        chk("t4_addr", {28'd0, bus.reg_addr}, 32'd1);
        clear_log();
        i2c_start();
        send_byte(8'h54, a);
        send_byte(8'hF3, a);
        send_byte(8'h44, a);
        i2c_stop();
        chk("t4_nwr_b", wlog.size(), 32'd1);
        chk("t4_wr_b", {20'd0, wlog[0]}, 32'h344);
        chk("t4_addr_b", {28'd0, bus.reg_addr}, 32'd4);

        // STOP after a partial data byte
        clear_log();
        i2c_start();
        send_byte(8'h54, a);
        send_byte(8'h02, a);
        for (int i = 0; i < 5; i++) clk_bit(1'b1, s);
        i2c_stop();
        chk("t5_nwr", wlog.size(), 32'd0);
        chk("t5_busy", {31'd0, bus.busy}, 32'd0);
        chk("t5_addr", {28'd0, bus.reg_addr}, 32'd2);

        // Async reset while driving a read bit
        i2c_start();
        send_byte(8'h54, a);
        send_byte(8'h02, a);
        i2c_start();
        send_byte(8'h55, a);
        chk("t5_rd_oe", {31'd0, bus.sda_oe}, 32'd1);
        #3;
        rstn = 1'b0;
        #1;
        chk("t5_rst_oe", {31'd0, bus.sda_oe}, 32'd0);
        chk("t5_rst_addr", {28'd0, bus.reg_addr}, 32'd0);
        chk("t5_rst_busy", {31'd0, bus.busy}, 32'd0);
        #6;
        #(2*CP);
        sda_ctrl = 1'b1;
        rstn = 1'b1;
        hq();
        scl = 1'b1;
        hq();
        chk("t5_idle_oe", {31'd0, bus.sda_oe}, 32'd0);
        chk("t5_idle_busy", {31'd0, bus.busy}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/i2c_reg_target.md
Name: i2c_reg_target

Overview:
I2C target (slave) front end that owns the bus side of the PPT controller's 16-entry register map. It decodes I2C transactions from an external controller and turns them into single-cycle register writes and combinational register reads on the map's address/data interface. SCL and SDA are oversampled on the system clock. SDA is open-drain, driven only low. The block never stretches SCL.

Parameters:
I2C_ADDR, 7'h2A, 7-bit target address matched against the first byte after START.
SYNC_STAGES, 2, flip-flop stages on scl_in/sda_in before edge detection (min 2).

Ports:
clk  input  1  system clock; must be >= 16x SCL frequency
rstn  input  1  reset; asynchronous, active-low
scl_in  input  1  raw SCL pad input
sda_in  input  1  raw SDA pad input
sda_oe  output  1  1 = pull SDA low (pad drives 0), 0 = release
reg_addr  output  4  register pointer presented to register map
reg_wdata  output  8  write data to register map
reg_we  output  1  one-clk write strobe
reg_rdata  input  8  read data from register map (combinational on reg_addr)
busy  output  1  1 from accepted address match until STOP/START/NACK end

Behaviour:
- Reset (async): state IDLE, sda_oe=0, reg_we=0, reg_addr=0, reg_wdata=0, busy=0, bit counter=0, shift reg=0. Asserting rstn low mid-transfer releases SDA immediately.
- Sync: scl_s/sda_s pass through SYNC_STAGES FFs, plus one delay FF for edge detect. All decisions use synchronized values.
- START: sda_s falls while scl_s high. Valid in any state. A repeated START re-enters ADDR; the pointer is kept.
- STOP: sda_s rises while scl_s high. Valid in any state; goes to IDLE. A partial byte is discarded and gives no reg_we.
- Data is sampled MSB first on the scl_s rising edge. sda_oe changes only on the clk after a scl_s falling edge.
- States: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT_STOP.
- ADDR: shift 8 bits; decide at the falling edge after bit 8.
  - Match with R/W=0: go to ADDR_ACK, drive ACK (sda_oe=1 for one SCL period), then PTR.
  - Match with R/W=1: ACK, then RDATA.
  - Mismatch: no ACK, go to WAIT_STOP, busy stays 0.
- PTR: 8 bits received; reg_addr <= byte[3:0] (upper nibble ignored). ACK, then WDATA.
- WDATA: at the falling edge after bit 8:
  - reg_wdata <= byte and reg_we=1 for exactly one clk, with reg_addr = current pointer.
  - Next clk: reg_addr increments.
  - ACK, then WDATA again.
- RDATA:
  - On the scl falling edge that ends the ACK phase, load shift <= reg_rdata (pointer value at that clk).
  - Drive sda_oe = ~shift[7] for bit 7, then subsequent bits on each falling edge.
  - After bit 0's falling edge, release SDA, increment reg_addr, go to RDATA_ACK.
- RDATA_ACK: sample the controller's bit on the SCL rise. 0 = ACK, go to RDATA (next byte loaded on the falling edge). 1 = NACK, go to WAIT_STOP with SDA released.
- Pointer wrap: 4'hF + 1 = 4'h0 for both reads and writes.
- WAIT_STOP: SDA released, ignore bits until START or STOP.
- busy = 1 in every state from ADDR_ACK (match) to exit to IDLE/WAIT_STOP/ADDR.
- START and STOP on the same clk cannot occur. A STOP during an ACK phase releases SDA on that clk.
- No bus timeout. Unmapped addresses are handled by the register map; this block writes and reads them blindly.

Test Plan:
1. Write burst: START, 0x54, 0x01, 0xA5, 0x00, 0x02, STOP → three ACKs after address/pointer/data; reg_we pulses with (addr,wdata) = (1,A5),(2,00),(3,02); reg_addr=4 after; busy returns to 0 after STOP.
2. Read with repeated START: START, 0x54, 0x07, Sr, 0x55, read 2 bytes (ACK then NACK), STOP, with map returning 0x01 @7 and 0x3C @8 → bytes 0x01, 0x3C on SDA; reg_addr=9; no reg_we.
3. Address mismatch: START, 0x60, 0x05, 0xFF, STOP → no ACK on any byte, sda_oe stays 0, no reg_we, busy stays 0.
4. Wrap: write pointer 0x0F, data 0x11, 0x22 → writes at addr F then 0; pointer field 0xF3 behaves as 0x3.
5. Aborts: STOP after 5 data bits of a write → no reg_we, state IDLE. rstn low while sda_oe=1 during a read → sda_oe=0 asynchronously, reg_addr=0.
6. Timing: reg_we is high exactly 1 clk; sda_oe never toggles while scl_s is high, checked by assertion across all tests.
